// File: rtl/fetch_queue.sv
// fetch_queue: circular FIFO of {PC, instruction} pairs between fetch and decode.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue pass input straight to outputs.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic [31:0]              PCResult,
    input  logic [31:0]              Instruction,
    input  logic                     FetchValid,
    input  logic                     DecodeReady,
    input  logic                     Flush,
    output logic [31:0]              InstructionOut,
    output logic [31:0]              PCPlus4Out,
    output logic                     OutValid,
    output logic                     FetchStall,
    output logic [$clog2(DEPTH):0]   Count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]   pc_mem [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          empty, bypass, push, pop;

    assign empty      = Count == '0;
    assign FetchStall = Count == (AW+1)'(DEPTH);
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty && FetchValid && !Flush;
`else
    assign bypass = 1'b0;
`endif
    // A bypassed pair taken by decode this cycle never enters the array
    assign push = FetchValid && !FetchStall && !Flush && !(bypass && DecodeReady);
    assign pop  = !empty && DecodeReady && !Flush;

    assign OutValid       = !empty || bypass;
    assign InstructionOut = bypass ? Instruction : (empty ? 32'h0 : instr_mem[rd_ptr]);
    assign PCPlus4Out     = bypass ? PCResult + 32'd4 : (empty ? 32'h0 : pc_mem[rd_ptr] + 32'd4);

    always_ff @(posedge Clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= PCResult;
            instr_mem[wr_ptr] <= Instruction;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || Flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            Count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            Count <= Count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;
    logic        Clk, Reset, FetchValid, DecodeReady, Flush;
    logic [31:0] PCResult, Instruction, InstructionOut, PCPlus4Out;
    logic        OutValid, FetchStall;
    logic [2:0]  Count;
    int          checks = 0, errors = 0;

    fetch_queue #(.DEPTH(4)) dut (
        .Clk(Clk), .Reset(Reset), .PCResult(PCResult), .Instruction(Instruction),
        .FetchValid(FetchValid), .DecodeReady(DecodeReady), .Flush(Flush),
        .InstructionOut(InstructionOut), .PCPlus4Out(PCPlus4Out),
        .OutValid(OutValid), .FetchStall(FetchStall), .Count(Count)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic dr);
        FetchValid  = fv;
        PCResult    = pc;
        Instruction = pc ^ 32'hA5A5_0000;
        DecodeReady = dr;
        #1;
    endtask

    initial begin
        Reset = 1; Flush = 0;
        drive(0, 0, 0);
        cyc();
        Reset = 0;
        #1;
        check("rst_count", 32'(Count), 0);
        check("rst_valid", 32'(OutValid), 0);
        check("rst_stall", 32'(FetchStall), 0);
        check("rst_instr", InstructionOut, 0);
        check("rst_pc4", PCPlus4Out, 0);

        // fill to full, then a dropped fifth push, then drain in order
        for (int i = 0; i < 4; i++) begin
            drive(1, 100 + 4 * i, 0);
            cyc();
        end
        drive(0, 0, 0);
        check("full_count", 32'(Count), 4);
        check("full_stall", 32'(FetchStall), 1);
        drive(1, 116, 1);
        check("full_head_pc4", PCPlus4Out, 104);
        cyc();
        drive(0, 0, 1);
        check("drop_count", 32'(Count), 3);
        for (int i = 1; i < 4; i++) begin
            check("drain_pc4", PCPlus4Out, 104 + 4 * i);
            check("drain_instr", InstructionOut, (100 + 4 * i) ^ 32'hA5A5_0000);
            cyc();
        end
        check("drained_count", 32'(Count), 0);
        check("drained_valid", 32'(OutValid), 0);
        check("drained_instr", InstructionOut, 0);
        cyc();
        check("pop_empty_count", 32'(Count), 0);

        // simultaneous push and pop at Count=2
        for (int i = 0; i < 2; i++) begin
            drive(1, 400 + 4 * i, 0);
            cyc();
        end
        drive(1, 408, 1);
        check("pp_head_before", PCPlus4Out, 404);
        cyc();
        drive(0, 0, 1);
        check("pp_count", 32'(Count), 2);
        check("pp_head_after", PCPlus4Out, 408);
        cyc();
        check("pp_next", PCPlus4Out, 412);
        cyc();
        check("pp_empty", 32'(Count), 0);

        // flush with a concurrent push
        for (int i = 0; i < 3; i++) begin
            drive(1, 500 + 4 * i, 0);
            cyc();
        end
        check("pre_flush_count", 32'(Count), 3);
        Flush = 1;
        drive(1, 512, 1);
        cyc();
        Flush = 0;
        drive(0, 0, 0);
        check("flush_count", 32'(Count), 0);
        check("flush_valid", 32'(OutValid), 0);
        drive(1, 200, 0);
        cyc();
        drive(0, 0, 0);
        check("post_flush_pc4", PCPlus4Out, 204);
        check("post_flush_count", 32'(Count), 1);
        drive(0, 0, 1);
        cyc();

        // PC+4 wraps to zero
        drive(1, 32'hFFFF_FFFC, 0);
        cyc();
        drive(0, 0, 0);
        check("wrap_pc4", PCPlus4Out, 0);
        check("wrap_valid", 32'(OutValid), 1);
        drive(0, 0, 1);
        cyc();

        // pointer wrap: six push/pop pairs keep order
        drive(1, 600, 0);
        cyc();
        for (int k = 0; k < 6; k++) begin
            drive(1, 604 + 4 * k, 1);
            check("ptr_wrap_head", PCPlus4Out, 604 + 4 * k);
            cyc();
        end
        drive(0, 0, 1);
        check("ptr_wrap_last", PCPlus4Out, 628);
        check("ptr_wrap_count", 32'(Count), 1);
        cyc();

        // arrival latency into an empty queue with decode ready
        drive(1, 300, 1);
`ifdef FETCH_QUEUE_BYPASS_EN
        check("byp_valid", 32'(OutValid), 1);
        check("byp_pc4", PCPlus4Out, 304);
        cyc();
        drive(0, 0, 0);
        check("byp_count", 32'(Count), 0);
`else
        check("lat_valid_same", 32'(OutValid), 0);
        cyc();
        drive(0, 0, 0);
        check("lat_valid_next", 32'(OutValid), 1);
        check("lat_pc4", PCPlus4Out, 304);
        check("lat_count", 32'(Count), 1);
`endif

        // reset mid-operation beats push and flush
        drive(1, 700, 0);
        cyc();
        Reset = 1; Flush = 1;
        drive(1, 704, 1);
        cyc();
        Reset = 0; Flush = 0;
        drive(0, 0, 0);
        check("mid_rst_count", 32'(Count), 0);
        check("mid_rst_valid", 32'(OutValid), 0);
        check("mid_rst_pc4", PCPlus4Out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >= 2).
REQ-002 SHALL have port Clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port PCResult  input  32  address of the fetched instruction, from the program counter.
REQ-005 SHALL have port Instruction  input  32  instruction word read from instruction memory at PCResult.
REQ-006 SHALL have port FetchValid  input  1  PCResult/Instruction pair is valid this cycle.
REQ-007 SHALL have port DecodeReady  input  1  decode stage accepts the head entry this cycle.
REQ-008 SHALL have port Flush  input  1  discard all queued entries (branch/jump redirect).
REQ-009 SHALL have port InstructionOut  output  32  head-entry instruction.
REQ-010 SHALL have port PCPlus4Out  output  32  head-entry PCResult + 4.
REQ-011 SHALL have port OutValid  output  1  head entry valid.
REQ-012 SHALL have port FetchStall  output  1  queue full; upstream holds PC.
REQ-013 SHALL have port Count  output  log2(DEPTH)+1  current occupancy.

Function
REQ-014 SHALL push {PCResult, Instruction} at rising edge when FetchValid=1 and FetchStall=0; else input dropped.
REQ-015 SHALL pop head at rising edge when OutValid=1 and DecodeReady=1; DecodeReady while empty has no effect.
REQ-016 SHALL support simultaneous push and pop in one cycle: Count unchanged, both pointers advance.
REQ-017 SHALL drop a push while Count=DEPTH even if a pop occurs in the same cycle (FetchStall is purely Count-based).
REQ-018 SHALL drive FetchStall=1 iff Count=DEPTH, OutValid=1 iff Count!=0 (combinational from registered state).
REQ-019 SHALL drive InstructionOut and PCPlus4Out combinationally from head entry when OutValid=1; both 32'h00000000 when OutValid=0.
REQ-020 SHALL compute PCPlus4Out as PCResult+4 modulo 2^32 (32'hFFFFFFFC -> 32'h00000000, no carry out).
REQ-021 SHALL wrap read and write pointers modulo DEPTH.
REQ-022 SHALL preserve FIFO order; entries leave exactly in push order.
REQ-023 SHALL, on Flush=1, set Count=0 and both pointers to 0 at next edge; push and pop in same cycle ignored.
REQ-024 SHALL have minimum latency of 1 cycle from push to OutValid (without bypass).

Reset
REQ-025 SHALL, on Reset=1 at rising edge, set Count=0, pointers=0; outputs then OutValid=0, FetchStall=0, InstructionOut=0, PCPlus4Out=0.
REQ-026 SHALL give Reset priority over Flush, push and pop; reset mid-operation discards all entries.
REQ-027 SHALL not require storage-array reset; array contents unobservable while invalid.

Configuration
REQ-028 SHALL, with macro FETCH_QUEUE_BYPASS_EN defined, when Count=0 and FetchValid=1 and Flush=0, drive OutValid=1 and present incoming pair on outputs same cycle; if DecodeReady=1 the pair is consumed and not written (Count stays 0), else it is written normally.
REQ-029 SHALL, without FETCH_QUEUE_BYPASS_EN, never present an input on outputs in the cycle it arrives (latency per REQ-024).

Verification
REQ-030 SHALL cover: Reset=1 one cycle -> Count=0, OutValid=0, FetchStall=0, outputs 0.
REQ-031 SHALL cover: push PC 100,104,108,112 (DecodeReady=0) -> Count=4, FetchStall=1; fifth push PC 116 dropped; drain -> PCPlus4Out 104,108,112,116 in order.
REQ-032 SHALL cover: Count=2, FetchValid=1 and DecodeReady=1 same cycle -> Count stays 2, head advances.
REQ-033 SHALL cover: Count=3, Flush=1 with FetchValid=1 -> next cycle Count=0, OutValid=0; push PC 200 afterward -> PCPlus4Out=204.
REQ-034 SHALL cover: push PC 32'hFFFFFFFC -> PCPlus4Out=32'h00000000; pointer wrap after 6 push/pop pairs keeps order.
REQ-035 SHALL cover: with FETCH_QUEUE_BYPASS_EN, empty, push PC 300 with DecodeReady=1 -> same-cycle OutValid=1, PCPlus4Out=304, Count remains 0; without macro -> OutValid=0 that cycle, 1 next.
